fetch_queue: RTL

//  Parametrised instruction buffer between fetch and decode; replaces the single fetch/decode

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/fetch_queue.sv | 85 ++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, bubble encodings and
// the fetch-queue entry layout.
package rv32i_pkg;

  localparam int unsigned PC_W   = 13;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0]   BUBBLE_PC   = '0;
  localparam logic [INST_W-1:0] BUBBLE_INST = 32'd0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry {pc, inst} queue with
// valid/ready on both sides, one-cycle flush, and a bubble driven when empty.
module fetch_queue #(
  parameter int unsigned PC_W   = rv32i_pkg::PC_W,
  parameter int unsigned INST_W = rv32i_pkg::INST_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            pcF,
  input  logic [INST_W-1:0]          instF,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            pcC,
  output logic [INST_W-1:0]          instC,
  output logic [$clog2(DEPTH):0]     level
);

  import rv32i_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head;

  // Handshakes depend on registered state only, so no input reaches an output.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign level     = count;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head  = mem[rd_ptr];
    pcC   = PC_W'(BUBBLE_PC);
    instC = INST_W'(BUBBLE_INST);
    if (out_valid) begin
      pcC   = head.pc;
      instC = head.inst;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write during reset or flush is harmless but suppressed anyway.
  always_ff @(posedge CLK) begin
    if (NRST && !flush && push) begin
      mem[wr_ptr] <= '{pc: pcF, inst: instF};
    end
  end

endmodule
